// File: rtl/cm82a_digit_serial_adder_if.sv
// ---------------------------------------------------------------------------
// cm82a_digit_serial_adder_if
// Bundle of the operand-in and result-out handshakes for the digit-serial
// cm82a adder.
//   DIGITS     : number of 2-bit digits per operand (W = 2*DIGITS)
//   in_valid   : operand word offered          (producer -> adder)
//   in_ready   : adder can accept a word        (adder -> producer)
//   in_a/in_b  : W-bit operands, in_cin carry-in for digit 0
//   out_valid  : result held on out_sum/out_cout (adder -> consumer)
//   out_ready  : consumer accepts the result    (consumer -> adder)
// Modports: slave = adder side, master = producer/consumer side.
// ---------------------------------------------------------------------------
interface cm82a_digit_serial_adder_if #(
  parameter int DIGITS = 4
) ();
  localparam int W = 2 * DIGITS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );
endinterface

// File: rtl/cm82a_digit_serial_adder.sv
// ---------------------------------------------------------------------------
// cm82a_digit_serial_adder
// Word-width adder built by iterating the cm82a 2-bit full-adder slice over
// one digit per cycle, LSB digit first, with the slice carry-out registered
// and fed back as the next digit's carry-in.
//
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   bus       : cm82a_digit_serial_adder_if.slave (operand in / result out)
//   dbg_state : current FSM state (0=IDLE, 1=RUN, 2=DONE)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE (and low while rst is high);
// out_valid is high only in DONE, and out_sum/out_cout are held stable
// until out_ready is sampled high.
//
// Optional feature macro CM82A_SATURATE_EN: when defined, a result with a
// final carry of 1 reads out_sum as all ones (out_cout still 1). The internal
// result register keeps the wrapped sum either way.
// ---------------------------------------------------------------------------
module cm82a_digit_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  cm82a_digit_serial_adder_if.slave      bus,
  output logic [1:0]                     dbg_state
);
  localparam int W  = 2 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  result_q, result_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Bit offset of the current digit (2*counter).
  logic [CW:0]   base;
  logic          a0, a1, b0, b1;
  logic          c1, s0, s1, co;
  logic          last_digit;

  // cm82a slice applied to the digit selected by the counter.
  always_comb begin
    base       = {cnt_q, 1'b0};
    {a1, a0}   = a_q[base +: 2];
    {b1, b0}   = b_q[base +: 2];
    s0         = a0 ^ b0 ^ carry_q;
    c1         = (a0 & b0) | (a0 & carry_q) | (b0 & carry_q);
    s1         = a1 ^ b1 ^ c1;
    co         = (a1 & b1) | (a1 & c1) | (b1 & c1);
    last_digit = (cnt_q == CW'(DIGITS - 1));
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d      = bus.in_a;
          b_d      = bus.in_b;
          carry_d  = bus.in_cin;
          cnt_d    = '0;
          result_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        result_d[base +: 2] = {s1, s0};
        carry_d             = co;
        // Counter holds at the last digit instead of wrapping.
        if (last_digit) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs are gated by DONE so partial results never leak onto the bus.
  always_comb begin
    bus.in_ready  = (state_q == IDLE) && !rst;
    bus.out_valid = (state_q == DONE);
    bus.out_cout  = (state_q == DONE) && carry_q;
`ifdef CM82A_SATURATE_EN
    if (state_q != DONE) begin
      bus.out_sum = '0;
    end else if (carry_q) begin
      bus.out_sum = '1;
    end else begin
      bus.out_sum = result_q;
    end
`else
    bus.out_sum = (state_q == DONE) ? result_q : '0;
`endif
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_cm82a_digit_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_cm82a_digit_serial_adder
// Directed bench for cm82a_digit_serial_adder: a DIGITS=4 instance for the
// word-level scenarios and a DIGITS=1 instance for the slice truth table.
// ---------------------------------------------------------------------------
module tb_cm82a_digit_serial_adder;
  logic       clk;
  logic       rst;
  logic [1:0] dbg4;
  logic [1:0] dbg1;

  int n_cmp;
  int n_err;

  logic [8:0] exp_q[$];

  cm82a_digit_serial_adder_if #(.DIGITS(4)) u4 ();
  cm82a_digit_serial_adder_if #(.DIGITS(1)) u1 ();

  cm82a_digit_serial_adder #(.DIGITS(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .bus       (u4.slave),
    .dbg_state (dbg4)
  );

  cm82a_digit_serial_adder #(.DIGITS(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .bus       (u1.slave),
    .dbg_state (dbg1)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected visible sum for a 9-bit {cout,sum} reference value.
  function automatic logic [7:0] vis_sum8(input logic [8:0] full);
`ifdef CM82A_SATURATE_EN
    return full[8] ? 8'hFF : full[7:0];
`else
    return full[7:0];
`endif
  endfunction

  // ---------------- driver tasks (DIGITS=4 instance) ----------------
  task automatic accept4(input logic [7:0] a, input logic [7:0] b, input logic cin);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!u4.in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!u4.in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", u4.in_ready);
    end
    u4.in_a     = a;
    u4.in_b     = b;
    u4.in_cin   = cin;
    u4.in_valid = 1'b1;
    @(posedge clk);
    #1;
    u4.in_valid = 1'b0;
    u4.in_a     = 8'hXX;
    u4.in_b     = 8'hXX;
    u4.in_cin   = 1'bx;
  endtask

  task automatic wait_valid4(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!u4.out_valid && lat < 20);
    if (!u4.out_valid) begin
      n_cmp++; n_err++;
      $display("FAIL valid_timeout: out_valid=%0b required 1", u4.out_valid);
    end
  endtask

  task automatic release4();
    u4.out_ready = 1'b1;
    @(posedge clk);
    #1;
    u4.out_ready = 1'b0;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_cmp++; if (u4.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %0b want 0", u4.in_ready); end
    n_cmp++; if (u4.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b want 0", u4.out_valid); end
    n_cmp++; if (u4.out_sum !== 8'h00) begin n_err++; $display("FAIL reset_out_sum: got %h want 00", u4.out_sum); end
    n_cmp++; if (u4.out_cout !== 1'b0) begin n_err++; $display("FAIL reset_out_cout: got %0b want 0", u4.out_cout); end
    n_cmp++; if (dbg4 !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", dbg4); end
    n_cmp++; if (u1.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready_d1: got %0b want 0", u1.in_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (u4.in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %0b want 1", u4.in_ready); end
  endtask

  task automatic test_basic();
    int lat;
    accept4(8'h5A, 8'h3C, 1'b0);
    wait_valid4(lat);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL basic_latency: got %0d want 4", lat); end
    n_cmp++; if (u4.out_sum !== 8'h96) begin n_err++; $display("FAIL basic_sum: got %h want 96", u4.out_sum); end
    n_cmp++; if (u4.out_cout !== 1'b0) begin n_err++; $display("FAIL basic_cout: got %0b want 0", u4.out_cout); end
    release4();
  endtask

  task automatic test_overflow();
    int lat;
    logic [7:0] want;
`ifdef CM82A_SATURATE_EN
    want = 8'hFF;
`else
    want = 8'h00;
`endif
    accept4(8'hFF, 8'h01, 1'b0);
    wait_valid4(lat);
    n_cmp++; if (u4.out_sum !== want) begin n_err++; $display("FAIL overflow_sum: got %h want %h", u4.out_sum, want); end
    n_cmp++; if (u4.out_cout !== 1'b1) begin n_err++; $display("FAIL overflow_cout: got %0b want 1", u4.out_cout); end
    release4();
  endtask

  task automatic test_full_carry();
    int lat;
    accept4(8'hFF, 8'hFF, 1'b1);
    wait_valid4(lat);
    n_cmp++; if (u4.out_sum !== 8'hFF) begin n_err++; $display("FAIL full_carry_sum: got %h want FF", u4.out_sum); end
    n_cmp++; if (u4.out_cout !== 1'b1) begin n_err++; $display("FAIL full_carry_cout: got %0b want 1", u4.out_cout); end
    release4();
  endtask

  task automatic test_backpressure();
    int lat;
    // 0x12 + 0x34 + 1 = 0x47
    accept4(8'h12, 8'h34, 1'b1);
    wait_valid4(lat);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_cmp++; if (u4.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %0b want 1", i, u4.out_valid); end
      n_cmp++; if (u4.out_sum !== 8'h47) begin n_err++; $display("FAIL bp_sum[%0d]: got %h want 47", i, u4.out_sum); end
      n_cmp++; if (u4.out_cout !== 1'b0) begin n_err++; $display("FAIL bp_cout[%0d]: got %0b want 0", i, u4.out_cout); end
      n_cmp++; if (u4.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %0b want 0", i, u4.in_ready); end
    end
    release4();
    n_cmp++; if (u4.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready: got %0b want 1", u4.in_ready); end
    n_cmp++; if (u4.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %0b want 0", u4.out_valid); end
    // out_ready while idle must not disturb anything.
    release4();
    n_cmp++; if (dbg4 !== 2'd0) begin n_err++; $display("FAIL idle_out_ready_state: got %0d want 0", dbg4); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    // Low two digits of 0xFF+0x01 leave carry=1 in the register.
    accept4(8'hFF, 8'h01, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (u4.in_ready !== 1'b0) begin n_err++; $display("FAIL midrst_in_ready: got %0b want 0", u4.in_ready); end
    n_cmp++; if (u4.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %0b want 0", u4.out_valid); end
    n_cmp++; if (u4.out_sum !== 8'h00) begin n_err++; $display("FAIL midrst_sum: got %h want 00", u4.out_sum); end
    n_cmp++; if (dbg4 !== 2'd0) begin n_err++; $display("FAIL midrst_state: got %0d want 0", dbg4); end
    @(negedge clk);
    rst = 1'b0;
    accept4(8'h01, 8'h02, 1'b0);
    wait_valid4(lat);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL midrst_latency: got %0d want 4", lat); end
    n_cmp++; if (u4.out_sum !== 8'h03) begin n_err++; $display("FAIL midrst_sum_after: got %h want 03", u4.out_sum); end
    n_cmp++; if (u4.out_cout !== 1'b0) begin n_err++; $display("FAIL midrst_cout_after: got %0b want 0", u4.out_cout); end
    release4();
  endtask

  task automatic test_back_to_back();
    logic [7:0] ta[3];
    logic [7:0] tb[3];
    logic       tc[3];
    logic [8:0] want;
    logic [8:0] got;
    int widx;
    int acc_cyc[3];
    int n_out;
    ta = '{8'h81, 8'h7F, 8'hC3};
    tb = '{8'h81, 8'h01, 8'h0F};
    tc = '{1'b1, 1'b0, 1'b1};
    widx  = 0;
    n_out = 0;
    u4.out_ready = 1'b1;
    @(negedge clk);
    u4.in_a = ta[0]; u4.in_b = tb[0]; u4.in_cin = tc[0]; u4.in_valid = 1'b1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (u4.out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL b2b_unexpected_output: sum=%h", u4.out_sum);
        end else begin
          want = exp_q.pop_front();
          got  = {u4.out_cout, u4.out_sum};
          n_cmp++;
          if (got !== {want[8], vis_sum8(want)}) begin
            n_err++;
            $display("FAIL b2b_result[%0d]: got %h want %h", n_out, got, {want[8], vis_sum8(want)});
          end
          n_out++;
        end
      end
      if (u4.in_ready && u4.in_valid && widx < 3) begin
        acc_cyc[widx] = cyc;
        exp_q.push_back(9'(ta[widx]) + 9'(tb[widx]) + 9'(tc[widx]));
        widx++;
        @(posedge clk);
        #1;
        if (widx < 3) begin
          u4.in_a = ta[widx]; u4.in_b = tb[widx]; u4.in_cin = tc[widx];
        end else begin
          u4.in_valid = 1'b0;
        end
      end
    end
    u4.out_ready = 1'b0;
    u4.in_valid  = 1'b0;
    n_cmp++; if (widx !== 3) begin n_err++; $display("FAIL b2b_accepts: got %0d want 3", widx); end
    n_cmp++; if (n_out !== 3) begin n_err++; $display("FAIL b2b_outputs: got %0d want 3", n_out); end
    if (widx == 3) begin
      n_cmp++; if (acc_cyc[1] - acc_cyc[0] !== 6) begin n_err++; $display("FAIL b2b_interval0: got %0d want 6", acc_cyc[1] - acc_cyc[0]); end
      n_cmp++; if (acc_cyc[2] - acc_cyc[1] !== 6) begin n_err++; $display("FAIL b2b_interval1: got %0d want 6", acc_cyc[2] - acc_cyc[1]); end
    end
    exp_q.delete();
  endtask

  task automatic test_digits1();
    logic [1:0] a, b;
    logic       cin;
    logic [2:0] full;
    logic [1:0] want_sum;
    int guard;
    for (int i = 0; i < 32; i++) begin
      cin  = i[4];
      a    = i[3:2];
      b    = i[1:0];
      full = 3'(a) + 3'(b) + 3'(cin);
`ifdef CM82A_SATURATE_EN
      want_sum = full[2] ? 2'b11 : full[1:0];
`else
      want_sum = full[1:0];
`endif
      @(negedge clk);
      u1.in_a = a; u1.in_b = b; u1.in_cin = cin; u1.in_valid = 1'b1;
      @(posedge clk);
      #1;
      u1.in_valid = 1'b0;
      guard = 0;
      do begin
        @(posedge clk);
        #1;
        guard++;
      end while (!u1.out_valid && guard < 10);
      n_cmp++;
      if (!u1.out_valid || {u1.out_cout, u1.out_sum} !== {full[2], want_sum}) begin
        n_err++;
        $display("FAIL d1_slice cin=%0b a=%0d b=%0d: got valid=%0b %b want %b", cin, a, b,
                 u1.out_valid, {u1.out_cout, u1.out_sum}, {full[2], want_sum});
      end
      u1.out_ready = 1'b1;
      @(posedge clk);
      #1;
      u1.out_ready = 1'b0;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    u4.in_valid = 1'b0; u4.in_a = '0; u4.in_b = '0; u4.in_cin = 1'b0; u4.out_ready = 1'b0;
    u1.in_valid = 1'b0; u1.in_a = '0; u1.in_b = '0; u1.in_cin = 1'b0; u1.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_full_carry();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_digits1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cm82a_digit_serial_adder.md
# cm82a_digit_serial_adder

Sequential stage that drives the cm82a 2-bit full-adder slice (carry-in, two operand bit-pairs, producing sum0, sum1 and carry-out). It accepts a wide operand pair, then feeds one 2-bit digit per cycle through the slice, LSB digit first. The slice carry-out is registered and returned as the next digit's carry-in. The assembled sum and final carry go out on a valid/ready interface, which lets the combinational slice be reused for word-width addition.

## Interface
- DIGITS, default 4: number of 2-bit digits per operand; operand width W = 2*DIGITS; legal range 1..16.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand word offered.
- in_ready  out  1  block can accept a word; high only in IDLE and never while rst is high.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_cin  in  1  carry-in for digit 0.
- out_valid  out  1  result held on out_sum/out_cout.
- out_ready  in  1  consumer accepts result.
- out_sum  out  W  sum, digit k in bits [2k+1:2k].
- out_cout  out  1  carry-out of the last digit.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. When in_valid&in_ready is high at an edge, latch in_a, in_b and in_cin into operand and carry registers, clear the digit counter, and go to RUN.
  - RUN: each cycle, apply the slice to digit k = counter. Operand bits a0,a1,b0,b1 come from bits [2k+1:2k].
  - Slice equations: s0=a0^b0^c; c1=maj(a0,b0,c); s1=a1^b1^c1; co=maj(a1,b1,c1).
  - At the edge, write {s1,s0} into result bits [2k+1:2k], set carry register to co, and increment the counter.
  - When k=DIGITS-1, go to DONE.
  - DONE: out_valid=1; out_sum and out_cout are held stable. When out_ready is high at an edge, go to IDLE.
- Result equals (in_a+in_b+in_cin) mod 2^W; out_cout is bit W of the full sum.
- Counter width is clog2(DIGITS) with a minimum of 1; it never wraps past DIGITS-1.
- Inputs arriving while in_ready=0 are ignored; in_a, in_b and in_cin need only be valid in the accept cycle.
- Reset at any time: state=IDLE, counter=0, carry=0, operand/result registers=0. Any partial result is discarded with no output.
- Reset values: in_ready=0 while rst is high, 1 after deassertion; out_valid=0; out_sum=0; out_cout=0.

## Timing
- Accept at edge T. Digits are processed at edges T+1..T+DIGITS, and out_valid rises after edge T+DIGITS. Latency is DIGITS cycles.
- in_ready stays low from the edge after accept until the cycle after the output handshake.
- Back-to-back throughput is one word per DIGITS+2 cycles.
- out_valid stays high, and data stays stable, until out_ready is sampled high; there is no drop without handshake.
- out_ready high while out_valid is low has no effect.
- Simultaneous rst and handshake: rst wins.

## Configuration
- CM82A_SATURATE_EN defined: in DONE, if the final carry is 1, out_sum reads all ones; out_cout still reports 1. The internal result register is unchanged.
- Not defined: out_sum is always the wrapped sum.

## Test plan
- DIGITS=4: a=0x5A, b=0x3C, cin=0 -> out_sum=0x96, out_cout=0; out_valid rises exactly 4 cycles after the accept edge.
- DIGITS=4: a=0xFF, b=0x01, cin=0 -> out_cout=1; out_sum=0x00 without the macro, 0xFF with CM82A_SATURATE_EN.
- DIGITS=4: a=0xFF, b=0xFF, cin=1 -> out_sum=0xFF, out_cout=1, with carry propagating through all digits.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> out_valid, out_sum and out_cout are stable and in_ready=0. Raise out_ready -> IDLE next cycle, in_ready=1.
- Reset mid-RUN: assert rst after 2 digits -> all outputs go to 0 immediately (asynchronously). A new word accepted after release yields the correct sum, with no stale carry.
- DIGITS=1: exhaustive 32 combinations of {cin, a[1:0], b[1:0]} -> {out_cout,out_sum} equals a+b+cin. This matches the combinational slice truth table.
